enemy_swarm_ctrl: RTL and testbench



---
 rtl/enemy_swarm_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_enemy_swarm_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_swarm_ctrl.sv
// enemy_swarm_ctrl
// Per-frame formation controller for the enemy swarm. On each frame edge it
// decides whether the swarm steps and in which direction. It tracks the
// swarm's top-left corner and counts survivors, and the survivor count sets
// the step rate. It also flags wave-cleared and invasion to game control.
//
// Ports
//   frame_clk          in   one rising edge per video frame
//   Reset              in   synchronous, active-high
//   start              in   level; begins/restarts a wave from IDLE/CLEARED/INVADED
//   is_playing         in   level; 0 pauses movement (kills still counted)
//   kill               in   one-frame pulse, one enemy destroyed
//   enemy_direction_X  out  0 = left, 1 = right
//   enemy_direction_Y  out  1 while descending (whole DROP phase)
//   enemy_move_en      out  1 on frames where sprites step 1 px
//   swarm_x, swarm_y   out  swarm top-left, 10-bit unsigned
//   alive_count        out  surviving enemies
//   delete_enemies     out  one-frame pulse clearing all sprites
//   wave_cleared       out  level while CLEARED
//   invaded            out  level while INVADED
//   o_dbg_state        out  current FSM state (debug visibility)
module enemy_swarm_ctrl #(
  parameter int NUM_ENEMIES = 16,
  parameter int SWARM_W     = 230,
  parameter int SWARM_H     = 230,
  parameter int START_X     = 40,
  parameter int START_Y     = 40,
  parameter int LEFT_LIMIT  = 8,
  parameter int RIGHT_LIMIT = 632,
  parameter int DROP_PX     = 10,
  parameter int INVADE_Y    = 400
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       is_playing,
  input  logic       kill,
  output logic       enemy_direction_X,
  output logic       enemy_direction_Y,
  output logic       enemy_move_en,
  output logic [9:0] swarm_x,
  output logic [9:0] swarm_y,
  output logic [4:0] alive_count,
  output logic       delete_enemies,
  output logic       wave_cleared,
  output logic       invaded,
  output logic [2:0] o_dbg_state
);
  localparam int DW = $clog2(DROP_PX + 1);

  localparam logic [4:0]    L_NUM     = 5'(NUM_ENEMIES);
  localparam logic [9:0]    L_START_X = 10'(START_X);
  localparam logic [9:0]    L_START_Y = 10'(START_Y);
  localparam logic [9:0]    L_LEFT    = 10'(LEFT_LIMIT);
  localparam logic [10:0]   L_SWARM_W = 11'(SWARM_W);
  localparam logic [10:0]   L_SWARM_H = 11'(SWARM_H);
  localparam logic [10:0]   L_RIGHT   = 11'(RIGHT_LIMIT);
  localparam logic [10:0]   L_INVADE  = 11'(INVADE_Y);
  localparam logic [DW-1:0] L_DROP    = DW'(DROP_PX);

  typedef enum logic [2:0] {IDLE, MOVE_H, DROP, CLEARED, INVADED} state_t;

  state_t        r_state;
  logic          r_dir_x, r_dir_y, r_move_en, r_delete, r_cleared, r_invaded;
  logic [9:0]    r_x, r_y;
  logic [4:0]    r_alive;
  logic [1:0]    r_frame_cnt;
  logic [DW-1:0] r_drop_cnt;

  state_t        w_next_state;
  logic          w_next_dir_x, w_next_dir_y, w_delete, w_load;
  logic [9:0]    w_next_x, w_next_y;
  logic [4:0]    w_next_alive;
  logic [1:0]    w_next_frame_cnt, w_period_m1;
  logic [DW-1:0] w_next_drop_cnt, w_drop_inc;
  logic [9:0]    w_step_x, w_step_y;
  logic          w_active, w_tick, w_edge_hit;

  // Move period minus one, from the survivor count: fewer enemies, faster swarm.
  always_comb begin
    if (r_alive >= 5'd12)     w_period_m1 = 2'd3;
    else if (r_alive >= 5'd8) w_period_m1 = 2'd2;
    else if (r_alive >= 5'd4) w_period_m1 = 2'd1;
    else                      w_period_m1 = 2'd0;
  end

  assign w_active   = (r_state == MOVE_H) || (r_state == DROP);
  // ">=" so a period shortened mid-count fires on the next frame.
  assign w_tick     = w_active && is_playing && (r_frame_cnt >= w_period_m1);
  assign w_step_x   = r_dir_x ? r_x + 10'd1 : r_x - 10'd1;
  assign w_step_y   = r_y + 10'd1;
  assign w_drop_inc = r_drop_cnt + 1'b1;
  // 11-bit sum so the right-edge compare cannot wrap.
  assign w_edge_hit = r_dir_x ? (({1'b0, w_step_x} + L_SWARM_W) >= L_RIGHT)
                              : (w_step_x <= L_LEFT);

  always_comb begin
    w_next_state     = r_state;
    w_next_x         = r_x;
    w_next_y         = r_y;
    w_next_dir_x     = r_dir_x;
    w_next_dir_y     = r_dir_y;
    w_next_alive     = r_alive;
    w_next_frame_cnt = r_frame_cnt;
    w_next_drop_cnt  = r_drop_cnt;
    w_delete         = 1'b0;
    w_load           = 1'b0;
    case (r_state)
      IDLE: w_load = start;
      CLEARED, INVADED: begin
        w_load   = start;
        w_delete = start;
      end
      default: begin
        if (is_playing) w_next_frame_cnt = w_tick ? 2'd0 : r_frame_cnt + 2'd1;
        if (w_tick) begin
          if (r_state == MOVE_H) begin
            w_next_x = w_step_x;
            if (w_edge_hit) begin
              w_next_state    = DROP;
              w_next_drop_cnt = '0;
              w_next_dir_y    = 1'b1;
            end
          end else begin
            w_next_y        = w_step_y;
            w_next_drop_cnt = w_drop_inc;
            if (w_drop_inc == L_DROP) begin
              w_next_state = MOVE_H;
              w_next_dir_x = ~r_dir_x;
              w_next_dir_y = 1'b0;
            end
          end
        end
        // Invasion beats edge handling; entering a terminal state holds direction.
        if (({1'b0, w_next_y} + L_SWARM_H) >= L_INVADE) begin
          w_next_state = INVADED;
          w_next_dir_x = r_dir_x;
          w_next_dir_y = r_dir_y;
        end
        // Last kill beats invasion on the same frame.
        if (kill && (r_alive != 5'd0)) begin
          w_next_alive = r_alive - 5'd1;
          if (r_alive == 5'd1) begin
            w_next_state = CLEARED;
            w_delete     = 1'b1;
            w_next_dir_x = r_dir_x;
            w_next_dir_y = r_dir_y;
          end
        end
      end
    endcase
    if (w_load) begin
      w_next_state     = MOVE_H;
      w_next_x         = L_START_X;
      w_next_y         = L_START_Y;
      w_next_alive     = L_NUM;
      w_next_dir_x     = 1'b1;
      w_next_dir_y     = 1'b0;
      w_next_frame_cnt = 2'd0;
      w_next_drop_cnt  = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b0;
      r_move_en   <= 1'b0;
      r_x         <= L_START_X;
      r_y         <= L_START_Y;
      r_alive     <= L_NUM;
      // A reset that interrupts a live wave clears the sprites once.
      r_delete    <= w_active;
      r_cleared   <= 1'b0;
      r_invaded   <= 1'b0;
      r_frame_cnt <= 2'd0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_dir_x     <= w_next_dir_x;
      r_dir_y     <= w_next_dir_y;
      r_move_en   <= w_tick;
      r_x         <= w_next_x;
      r_y         <= w_next_y;
      r_alive     <= w_next_alive;
      r_delete    <= w_delete;
      r_cleared   <= (w_next_state == CLEARED);
      r_invaded   <= (w_next_state == INVADED);
      r_frame_cnt <= w_next_frame_cnt;
      r_drop_cnt  <= w_next_drop_cnt;
    end
  end

  assign enemy_direction_X = r_dir_x;
  assign enemy_direction_Y = r_dir_y;
  assign enemy_move_en     = r_move_en;
  assign swarm_x           = r_x;
  assign swarm_y           = r_y;
  assign alive_count       = r_alive;
  assign delete_enemies    = r_delete;
  assign wave_cleared      = r_cleared;
  assign invaded           = r_invaded;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_enemy_swarm_ctrl.sv
// tb_enemy_swarm_ctrl
// Drives enemy_swarm_ctrl one frame at a time. Each frame is stepped through a
// behavioural model of the swarm rules, and every output is compared after
// every edge. Directed checks against fixed values cover the documented
// scenarios (start, bounce, speed scaling, clear, invasion, pause, reset).
module tb_enemy_swarm_ctrl;
  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1, start = 1'b0, is_playing = 1'b0, kill = 1'b0;
  logic       enemy_direction_X, enemy_direction_Y, enemy_move_en;
  logic [9:0] swarm_x, swarm_y;
  logic [4:0] alive_count;
  logic       delete_enemies, wave_cleared, invaded;
  logic [2:0] dbg_state;

  enemy_swarm_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .is_playing(is_playing),
    .kill(kill), .enemy_direction_X(enemy_direction_X),
    .enemy_direction_Y(enemy_direction_Y), .enemy_move_en(enemy_move_en),
    .swarm_x(swarm_x), .swarm_y(swarm_y), .alive_count(alive_count),
    .delete_enemies(delete_enemies), .wave_cleared(wave_cleared),
    .invaded(invaded), .o_dbg_state(dbg_state)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0;
  int checks = 0;

  // Model: game phase plus position, direction and counters as plain integers.
  localparam int M_IDLE = 0, M_MOVE = 1, M_DROP = 2, M_CLR = 3, M_INV = 4;
  int m_mode = M_IDLE;
  int m_x = 40, m_y = 40, m_alive = 16, m_cnt = 0, m_dcnt = 0;
  bit m_dx = 1, m_dy = 0, m_move = 0, m_del = 0, m_clr = 0, m_inv = 0;

  function automatic int period(input int alive);
    if (alive >= 12) return 4;
    if (alive >= 8)  return 3;
    if (alive >= 4)  return 2;
    return 1;
  endfunction

  task automatic model_load();
    m_x = 40; m_y = 40; m_alive = 16; m_dx = 1; m_dy = 0; m_cnt = 0; m_dcnt = 0;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit pl, input bit kl);
    int  nm;
    bit  ndx;
    bit  tick;
    m_move = 0;
    m_del  = 0;
    if (rst) begin
      m_del = (m_mode == M_MOVE) || (m_mode == M_DROP);
      model_load();
      m_mode = M_IDLE; m_clr = 0; m_inv = 0;
      return;
    end
    if (m_mode == M_IDLE || m_mode == M_CLR || m_mode == M_INV) begin
      if (st) begin
        m_del = (m_mode != M_IDLE);
        model_load();
        m_mode = M_MOVE; m_clr = 0; m_inv = 0;
      end
      return;
    end
    nm   = m_mode;
    ndx  = m_dx;
    tick = pl && (m_cnt >= period(m_alive) - 1);
    if (pl) m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) begin
      m_move = 1;
      if (m_mode == M_MOVE) begin
        m_x = m_dx ? m_x + 1 : m_x - 1;
        if ((m_dx && m_x + 230 >= 632) || (!m_dx && m_x <= 8)) begin
          nm = M_DROP; m_dcnt = 0;
        end
      end else begin
        m_y = m_y + 1;
        m_dcnt = m_dcnt + 1;
        if (m_dcnt == 10) begin nm = M_MOVE; ndx = !m_dx; end
      end
    end
    if (m_y + 230 >= 400) nm = M_INV;
    if (kl && m_alive > 0) begin
      m_alive = m_alive - 1;
      if (m_alive == 0) begin nm = M_CLR; m_del = 1; end
    end
    if (nm == M_MOVE || nm == M_DROP) begin
      m_dx = ndx;
      m_dy = (nm == M_DROP);
    end
    m_mode = nm;
    m_clr  = (nm == M_CLR);
    m_inv  = (nm == M_INV);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dir_x",   32'(enemy_direction_X), 32'(m_dx));
    chk("dir_y",   32'(enemy_direction_Y), 32'(m_dy));
    chk("move_en", 32'(enemy_move_en),     32'(m_move));
    chk("swarm_x", 32'(swarm_x),           32'(m_x));
    chk("swarm_y", 32'(swarm_y),           32'(m_y));
    chk("alive",   32'(alive_count),       32'(m_alive));
    chk("delete",  32'(delete_enemies),    32'(m_del));
    chk("cleared", 32'(wave_cleared),      32'(m_clr));
    chk("invaded", 32'(invaded),           32'(m_inv));
  endtask

  // One frame: apply inputs, advance the model, take the edge, compare.
  task automatic frame(input bit rst, input bit st, input bit pl, input bit kl);
    Reset = rst; start = st; is_playing = pl; kill = kl;
    model_step(rst, st, pl, kl);
    @(posedge frame_clk);
    #1;
    check_all();
  endtask

  initial begin
    // Clock/reset: two unchecked reset edges, then checked reset frames.
    repeat (2) @(posedge frame_clk);
    #1;
    frame(1, 0, 1, 0);
    frame(1, 0, 1, 0);
    chk("rst_x", 32'(swarm_x), 40);
    chk("rst_y", 32'(swarm_y), 40);
    chk("rst_alive", 32'(alive_count), 16);
    chk("rst_dir_x", 32'(enemy_direction_X), 1);
    chk("rst_delete", 32'(delete_enemies), 0);

    // Start: IDLE holds until start, then moves every 4th frame.
    frame(0, 0, 1, 0);
    frame(0, 1, 1, 0);
    chk("start_x", 32'(swarm_x), 40);
    chk("start_alive", 32'(alive_count), 16);
    chk("start_delete", 32'(delete_enemies), 0);
    for (int i = 0; i < 4; i++) begin
      frame(0, 0, 1, 0);
      chk("p4_move_en", 32'(enemy_move_en), (i == 3) ? 1 : 0);
    end
    chk("p4_x41", 32'(swarm_x), 41);

    // Pause: 20 frames frozen while 4 kills are still counted; start ignored.
    for (int i = 0; i < 20; i++) frame(0, (i == 7), 0, (i % 5 == 0));
    chk("pause_x", 32'(swarm_x), 41);
    chk("pause_alive", 32'(alive_count), 12);

    // Random play.
    for (int i = 0; i < 400; i++)
      frame(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 29) == 0));

    // Reset in the middle of a live wave pulses delete once.
    frame(1, 0, 1, 0);
    frame(0, 1, 1, 0);
    repeat (3) frame(0, 0, 1, 0);
    frame(1, 0, 1, 0);
    chk("rst_mid_delete", 32'(delete_enemies), 1);
    frame(1, 0, 1, 0);
    chk("rst_mid_delete_off", 32'(delete_enemies), 0);

    // Speed scaling: 13 kills leave 3 survivors, then a step every frame.
    frame(0, 1, 1, 0);
    for (int i = 0; i < 13; i++) frame(0, 0, 1, 1);
    chk("scale_alive", 32'(alive_count), 3);
    for (int i = 0; i < 5; i++) begin
      frame(0, 0, 1, 0);
      chk("scale_move_en", 32'(enemy_move_en), 1);
    end

    // Right bounce at swarm_x = 402, ten-pixel drop, then heading left.
    for (int n = 0; n < 1000 && m_mode != M_DROP; n++) frame(0, 0, 1, 0);
    chk("bounce_x", 32'(swarm_x), 402);
    chk("bounce_dir_y", 32'(enemy_direction_Y), 1);
    for (int i = 0; i < 10; i++) begin
      frame(0, 0, 1, 0);
      chk("drop_y", 32'(swarm_y), 41 + i);
      chk("drop_dir_y", 32'(enemy_direction_Y), (i < 9) ? 1 : 0);
    end
    chk("drop_flip", 32'(enemy_direction_X), 0);
    frame(0, 0, 1, 0);
    chk("left_x", 32'(swarm_x), 401);

    // Invasion: bottom edge reaches 400 during a drop.
    for (int n = 0; n < 20000 && m_mode != M_INV; n++) frame(0, 0, 1, 0);
    chk("inv_flag", 32'(invaded), 1);
    chk("inv_y", 32'(swarm_y), 170);
    for (int i = 0; i < 3; i++) begin
      frame(0, 0, 1, 0);
      chk("inv_frozen", 32'(enemy_move_en), 0);
    end

    // Restart from INVADED; last kill coinciding with invasion gives CLEARED.
    frame(0, 1, 1, 0);
    chk("restart_delete", 32'(delete_enemies), 1);
    chk("restart_alive", 32'(alive_count), 16);
    for (int i = 0; i < 15; i++) frame(0, 0, 1, 1);
    for (int n = 0; n < 20000 && !(m_mode == M_DROP && m_y == 169); n++)
      frame(0, 0, 1, 0);
    chk("pre_inv_y", 32'(swarm_y), 169);
    frame(0, 0, 1, 1);
    chk("tie_cleared", 32'(wave_cleared), 1);
    chk("tie_invaded", 32'(invaded), 0);
    chk("tie_delete", 32'(delete_enemies), 1);
    frame(0, 0, 1, 1);
    chk("sat_alive", 32'(alive_count), 0);
    chk("tie_delete_off", 32'(delete_enemies), 0);

    // Clear: 16 kills from a fresh wave.
    frame(0, 1, 1, 0);
    chk("new_wave_x", 32'(swarm_x), 40);
    chk("new_wave_y", 32'(swarm_y), 40);
    for (int i = 0; i < 16; i++) begin
      frame(0, 0, 1, 1);
      chk("clear_flag", 32'(wave_cleared), (i == 15) ? 1 : 0);
    end
    chk("clear_delete", 32'(delete_enemies), 1);
    frame(0, 0, 1, 0);
    chk("clear_delete_off", 32'(delete_enemies), 0);
    chk("clear_held", 32'(wave_cleared), 1);

    // Reset mid-DROP returns every output to its reset value.
    frame(0, 1, 1, 0);
    for (int i = 0; i < 13; i++) frame(0, 0, 1, 1);
    for (int n = 0; n < 1000 && m_mode != M_DROP; n++) frame(0, 0, 1, 0);
    frame(0, 0, 1, 0);
    chk("in_drop", 32'(enemy_direction_Y), 1);
    frame(1, 1, 1, 1);
    chk("rdrop_dir_y", 32'(enemy_direction_Y), 0);
    chk("rdrop_x", 32'(swarm_x), 40);
    chk("rdrop_y", 32'(swarm_y), 40);
    chk("rdrop_alive", 32'(alive_count), 16);
    chk("rdrop_delete", 32'(delete_enemies), 1);
    frame(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
